cache_mem_arbiter: RTL and testbench
====================================

// Module: cache_mem_arbiter
// PURPOSE
//  Shares the single 256-bit downstream line port (write buffer -> L2) between I-cache and D-cache.
//  Sits between the two L1 cache controllers and the write-buffer controller.
//  Latches the winner's request, holds it until the downstream port responds, and routes the response back.
//  Fixed D-cache priority, with a starvation counter that forces an I-cache grant.
// PARAMETERS
//  LINE_W      256  cache line width in bits
//  ADDR_W      32   line address width in bits
//  STARVE_MAX  4    consecutive D grants allowed while I is pending before I is forced; legal range 1..15
// PORTS
//  clk           in   1       clock; all state changes on posedge
//  rst_n         in   1       synchronous reset, active low
//  icache_read   in   1       I-cache line fill request, held until icache_resp
//  icache_addr   in   ADDR_W  I-cache line address
//  icache_rdata  out  LINE_W  fill data, valid only when icache_resp=1
//  icache_resp   out  1       single-cycle completion pulse to the I-cache
//  dcache_read   in   1       D-cache line fill request
//  dcache_write  in   1       D-cache writeback request; wins over dcache_read if both are set
//  dcache_addr   in   ADDR_W  D-cache line address
//  dcache_wdata  in   LINE_W  writeback line data
//  dcache_rdata  out  LINE_W  fill data, valid only when dcache_resp=1
//  dcache_resp   out  1       single-cycle completion pulse to the D-cache
//  mem_read      out  1       downstream read request
//  mem_write     out  1       downstream write request
//  mem_addr      out  ADDR_W  downstream address (registered)
//  mem_wdata     out  LINE_W  downstream write data (registered)
//  mem_rdata     in   LINE_W  downstream read data
//  mem_resp      in   1       downstream completion; may arrive in the same cycle as the request
// BEHAVIOUR
//  Reset (rst_n=0 at posedge):
//   - state=IDLE; starve_cnt=0.
//   - op/addr/wdata/owner registers cleared.
//   - All outputs 0 the cycle after reset.
//  States: IDLE, BUSY_I, BUSY_D (encoding in package).
//  IDLE:
//   - mem_read=mem_write=0.
//   - Arbitrate on the current request inputs:
//     force_i = icache_read & (starve_cnt==STARVE_MAX)
//     grant_d = (dcache_read|dcache_write) & ~force_i
//     grant_i = icache_read & ~grant_d
//   - On a grant, latch addr, wdata and op (op: WR if dcache_write, else RD), then go to BUSY_x.
//   - Arbitration latency: 1 cycle from request to mem_* assertion.
//  BUSY_x:
//   - mem_read = (op==RD); mem_write = (op==WR).
//   - mem_addr and mem_wdata come from the latched registers.
//   - Requester inputs are ignored; a requester dropping its request mid-grant does not abort the transaction.
//   - On mem_resp: x_resp=1 combinationally in the same cycle, x_rdata=mem_rdata, next state=IDLE.
//   - Without mem_resp, stay in BUSY_x indefinitely (no timeout).
//  Mandatory IDLE cycle after every response:
//   - mem_read/mem_write drop for at least 1 cycle between transactions.
//   - The write-buffer controller depends on mem_read falling to start its drain.
//  Non-owner resp is always 0. The rdata outputs may mirror mem_rdata at all times; they are qualified by resp only.
//  starve_cnt (4 bits, saturating at STARVE_MAX), updated on each grant in IDLE:
//   - +1 on a D grant while icache_read=1.
//   - Cleared on an I grant.
//   - Cleared in IDLE when icache_read=0.
//  Simultaneous I and D requests with starve_cnt<STARVE_MAX: D wins; I waits, holding its request.
//  Throughput: max one transaction per 2 cycles (zero-wait mem_resp).
//  Reset during BUSY: the transaction is abandoned, and no resp is issued to either cache.
// STRUCTURE
//  Package cache_arb_pkg: arb_state_e {IDLE,BUSY_I,BUSY_D}, mem_op_e {RD,WR}, LINE_W/ADDR_W defaults.
//  Single module, no sub-module. Sequential logic is the state register, request latch and starve_cnt; the rest is combinational.
// TESTING
//  1. I-only read, addr 0x0000_1000, mem_resp 3 cycles after mem_read -> mem_read high 1 cycle after request; icache_resp pulses 1 cycle; icache_rdata=mem_rdata.
//  2. D write, addr 0x0000_2040, wdata pattern A5.., mem_resp same cycle as mem_write -> dcache_resp the same cycle; mem_write low the next cycle (IDLE gap).
//  3. I and D read raised in the same cycle -> D served first; I served next, with exactly 1 IDLE cycle between the two mem_read pulses.
//  4. I held pending while D issues continuous back-to-back requests, STARVE_MAX=4 -> 4 D grants, then the 5th grant goes to I; starve_cnt=0 afterwards.
//  5. D drops dcache_read mid-BUSY_D; addr inputs change -> mem_addr keeps the latched value; dcache_resp still pulses on mem_resp.
//  6. rst_n=0 for 1 cycle during BUSY_I, then mem_resp=1 -> no icache_resp; state IDLE; all outputs 0.

Source files
------------

// File: rtl/cache_arb_pkg.sv
// Shared types and default widths for the L1 -> write-buffer line-port arbiter.
package cache_arb_pkg;

  localparam int DEF_LINE_W = 256;
  localparam int DEF_ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    RD = 1'b0,
    WR = 1'b1
  } mem_op_e;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Request/response bundle between the two L1 controllers, the arbiter and the downstream line port.
// master = arbiter view, slave = view of the surrounding caches and memory port.
interface cache_mem_arbiter_if
  import cache_arb_pkg::*;
#(
  parameter int LINE_W = DEF_LINE_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              icache_read;
  logic [ADDR_W-1:0] icache_addr;
  logic [LINE_W-1:0] icache_rdata;
  logic              icache_resp;

  logic              dcache_read;
  logic              dcache_write;
  logic [ADDR_W-1:0] dcache_addr;
  logic [LINE_W-1:0] dcache_wdata;
  logic [LINE_W-1:0] dcache_rdata;
  logic              dcache_resp;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  modport master (
    input  icache_read, icache_addr, dcache_read, dcache_write, dcache_addr, dcache_wdata,
           mem_rdata, mem_resp,
    output icache_rdata, icache_resp, dcache_rdata, dcache_resp,
           mem_read, mem_write, mem_addr, mem_wdata
  );

  modport slave (
    output icache_read, icache_addr, dcache_read, dcache_write, dcache_addr, dcache_wdata,
           mem_rdata, mem_resp,
    input  icache_rdata, icache_resp, dcache_rdata, dcache_resp,
           mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Shares one downstream line port between I-cache and D-cache: D has fixed priority,
// a starvation counter forces an I grant after STARVE_MAX consecutive D grants.
module cache_mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter int LINE_W     = DEF_LINE_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  cache_mem_arbiter_if.master bus
);

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  arb_state_e        state;
  mem_op_e           op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic [3:0]        starve_cnt;

  logic force_i, grant_d, grant_i;

  always_comb begin
    force_i = bus.icache_read && (starve_cnt == SMAX);
    grant_d = (bus.dcache_read || bus.dcache_write) && !force_i;
    grant_i = bus.icache_read && !grant_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= RD;
      addr_q     <= '0;
      wdata_q    <= '0;
      starve_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            addr_q  <= bus.dcache_addr;
            wdata_q <= bus.dcache_wdata;
            op_q    <= bus.dcache_write ? WR : RD;
            state   <= BUSY_D;
          end else if (grant_i) begin
            addr_q  <= bus.icache_addr;
            op_q    <= RD;
            state   <= BUSY_I;
          end
          // Counter only tracks D grants that actually made a waiting I wait longer.
          if (!bus.icache_read || grant_i)
            starve_cnt <= '0;
          else if (grant_d && starve_cnt < SMAX)
            starve_cnt <= starve_cnt + 4'd1;
        end
        BUSY_I, BUSY_D: if (bus.mem_resp) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Response is gated by rst_n so a reset that lands in BUSY never leaks a completion.
  assign bus.mem_read     = (state != IDLE) && (op_q == RD);
  assign bus.mem_write    = (state != IDLE) && (op_q == WR);
  assign bus.mem_addr     = addr_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.icache_resp  = rst_n && bus.mem_resp && (state == BUSY_I);
  assign bus.dcache_resp  = rst_n && bus.mem_resp && (state == BUSY_D);
  assign bus.icache_rdata = bus.icache_resp ? bus.mem_rdata : '0;
  assign bus.dcache_rdata = bus.dcache_resp ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: reset, I/D fills, writeback, priority, starvation, reset abort.
module tb_cache_mem_arbiter;

  localparam int LW = 256;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cache_mem_arbiter_if #(.LINE_W(LW), .ADDR_W(AW)) bus ();

  cache_mem_arbiter #(.LINE_W(LW), .ADDR_W(AW), .STARVE_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " mem_read"},     LW'(bus.mem_read), '0);
    chk({tag, " mem_write"},    LW'(bus.mem_write), '0);
    chk({tag, " mem_addr"},     LW'(bus.mem_addr), '0);
    chk({tag, " mem_wdata"},    bus.mem_wdata, '0);
    chk({tag, " icache_resp"},  LW'(bus.icache_resp), '0);
    chk({tag, " dcache_resp"},  LW'(bus.dcache_resp), '0);
    chk({tag, " icache_rdata"}, bus.icache_rdata, '0);
    chk({tag, " dcache_rdata"}, bus.dcache_rdata, '0);
  endtask

  initial begin
    logic [LW-1:0] pat_a5, rd1, rd2, rd3;
    pat_a5 = {32{8'hA5}};
    rd1    = {8{32'h1111_2222}};
    rd2    = {8{32'hCAFE_F00D}};
    rd3    = {8{32'h0BAD_BEEF}};

    bus.icache_read = 0; bus.icache_addr = '0;
    bus.dcache_read = 0; bus.dcache_write = 0; bus.dcache_addr = '0; bus.dcache_wdata = '0;
    bus.mem_rdata = '0; bus.mem_resp = 0;

    // reset
    cyc(); cyc();
    rst_n = 1;
    #1 chk_all_zero("reset");

    // 1: I-only read, resp 3 cycles after mem_read
    bus.icache_read = 1; bus.icache_addr = 32'h0000_1000;
    #1 chk("t1 no same-cycle grant", LW'(bus.mem_read), 0);
    cyc();
    chk("t1 mem_read", LW'(bus.mem_read), 1);
    chk("t1 mem_addr", LW'(bus.mem_addr), LW'(32'h0000_1000));
    cyc(); cyc();
    chk("t1 wait no resp", LW'(bus.icache_resp), 0);
    cyc();
    bus.mem_resp = 1; bus.mem_rdata = rd1;
    #1 chk("t1 icache_resp", LW'(bus.icache_resp), 1);
    chk("t1 icache_rdata", bus.icache_rdata, rd1);
    chk("t1 dcache_resp", LW'(bus.dcache_resp), 0);
    cyc();
    bus.icache_read = 0; bus.mem_resp = 0;
    #1 chk("t1 resp single pulse", LW'(bus.icache_resp), 0);
    chk("t1 idle gap", LW'(bus.mem_read), 0);

    // 2: D write, zero-wait resp
    bus.dcache_write = 1; bus.dcache_addr = 32'h0000_2040; bus.dcache_wdata = pat_a5;
    cyc();
    chk("t2 mem_write", LW'(bus.mem_write), 1);
    chk("t2 mem_read", LW'(bus.mem_read), 0);
    chk("t2 mem_addr", LW'(bus.mem_addr), LW'(32'h0000_2040));
    chk("t2 mem_wdata", bus.mem_wdata, pat_a5);
    bus.mem_resp = 1; bus.dcache_write = 0;
    #1 chk("t2 dcache_resp", LW'(bus.dcache_resp), 1);
    chk("t2 icache_resp", LW'(bus.icache_resp), 0);
    cyc();
    bus.mem_resp = 0;
    #1 chk("t2 mem_write gap", LW'(bus.mem_write), 0);
    chk("t2 dcache_resp drop", LW'(bus.dcache_resp), 0);

    // 3: simultaneous I and D read -> D first, one idle cycle, then I
    bus.icache_read = 1; bus.icache_addr = 32'h0000_3000;
    bus.dcache_read = 1; bus.dcache_addr = 32'h0000_4000;
    cyc();
    chk("t3 D first addr", LW'(bus.mem_addr), LW'(32'h0000_4000));
    bus.mem_resp = 1; bus.mem_rdata = rd2; bus.dcache_read = 0;
    #1 chk("t3 dcache_resp", LW'(bus.dcache_resp), 1);
    chk("t3 dcache_rdata", bus.dcache_rdata, rd2);
    cyc();
    bus.mem_resp = 0;
    #1 chk("t3 idle gap", LW'(bus.mem_read), 0);
    cyc();
    chk("t3 I second read", LW'(bus.mem_read), 1);
    chk("t3 I second addr", LW'(bus.mem_addr), LW'(32'h0000_3000));
    bus.mem_resp = 1;
    #1 chk("t3 icache_resp", LW'(bus.icache_resp), 1);
    cyc();
    bus.icache_read = 0; bus.mem_resp = 0;

    // 4: I pending under continuous D traffic -> 4 D grants then I
    bus.icache_read = 1; bus.icache_addr = 32'h0000_5000;
    bus.dcache_read = 1;
    for (int g = 0; g < 5; g++) begin
      bus.dcache_addr = 32'h0000_6000 + 32'(g) * 32'h40;
      cyc();
      chk($sformatf("t4 grant%0d addr", g), LW'(bus.mem_addr),
          (g < 4) ? LW'(32'h0000_6000 + 32'(g) * 32'h40) : LW'(32'h0000_5000));
      bus.mem_resp = 1;
      #1 chk($sformatf("t4 grant%0d dresp", g), LW'(bus.dcache_resp), LW'(g < 4));
      chk($sformatf("t4 grant%0d iresp", g), LW'(bus.icache_resp), LW'(g == 4));
      cyc();
      bus.mem_resp = 0;
      if (g == 4) begin bus.icache_read = 0; bus.dcache_read = 0; end
      #1 chk($sformatf("t4 gap%0d", g), LW'(bus.mem_read), 0);
    end
    // counter cleared: simultaneous request goes to D again
    bus.icache_read = 1; bus.dcache_read = 1; bus.dcache_addr = 32'h0000_6800;
    cyc();
    chk("t4 cnt cleared D wins", LW'(bus.mem_addr), LW'(32'h0000_6800));
    bus.mem_resp = 1; bus.dcache_read = 0; bus.icache_read = 0;
    cyc();
    bus.mem_resp = 0;

    // 5: D drops request and address changes mid-transaction
    cyc();
    bus.dcache_read = 1; bus.dcache_addr = 32'h0000_7000;
    cyc();
    bus.dcache_read = 0; bus.dcache_addr = 32'hDEAD_0000; bus.icache_addr = 32'hBEEF_0000;
    #1 chk("t5 addr held", LW'(bus.mem_addr), LW'(32'h0000_7000));
    cyc();
    chk("t5 still busy", LW'(bus.mem_read), 1);
    chk("t5 addr held2", LW'(bus.mem_addr), LW'(32'h0000_7000));
    bus.mem_resp = 1; bus.mem_rdata = rd3;
    #1 chk("t5 dcache_resp", LW'(bus.dcache_resp), 1);
    chk("t5 dcache_rdata", bus.dcache_rdata, rd3);
    cyc();
    bus.mem_resp = 0;

    // 6: reset during BUSY_I, then late mem_resp
    bus.icache_read = 1; bus.icache_addr = 32'h0000_8000;
    cyc();
    chk("t6 busy_i", LW'(bus.mem_read), 1);
    bus.icache_read = 0; rst_n = 0;
    cyc();
    rst_n = 1; bus.mem_resp = 1;
    #1 chk_all_zero("t6 after reset");
    cyc();
    bus.mem_resp = 0;
    #1 chk("t6 stays idle", LW'(bus.mem_read), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
